// File: rtl/tile_row_drain.sv
// tile_row_drain: captures a complete NUM_PE x NUM_PE tile in one edge and
// streams it out one row per handshake with a valid/ready interface.
// Optional macro TILE_DBUF_EN adds a second (pending) tile buffer so that a
// tile arriving mid-drain is queued and streamed back to back with no bubble.
// Without it, any tile arriving while a drain is in progress is dropped and
// flagged on the sticky ovf output.
module tile_row_drain #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PE     = 8,
  localparam int IDX_W     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_PE-1:0][NUM_PE-1:0][DATA_WIDTH-1:0] tile_in,
  input  logic                                         tile_val,
  output logic                                         tile_rdy,
  output logic [NUM_PE-1:0][DATA_WIDTH-1:0]            row_data,
  output logic                                         row_val,
  input  logic                                         row_ready,
  output logic [IDX_W-1:0]                             row_idx,
  output logic                                         row_last,
  output logic                                         ovf,
  input  logic                                         ovf_clr
);

  typedef enum logic [0:0] {IDLE, DRAIN} state_t;
  typedef logic [NUM_PE-1:0][NUM_PE-1:0][DATA_WIDTH-1:0] tile_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovf_q, ovf_d;
  tile_t            buf_q, buf_d;

  logic capture;
  logic row_hs;
  logic last_hs;

`ifdef TILE_DBUF_EN
  tile_t pend_q, pend_d;
  logic  pend_vld_q, pend_vld_d;

  // A new tile can be accepted whenever the pending slot is free.
  assign tile_rdy = !pend_vld_q;
`else
  // Single buffer: only accept while nothing is being drained.
  assign tile_rdy = (state_q == IDLE);
`endif

  assign capture = tile_val && tile_rdy;
  assign row_val = (state_q == DRAIN);
  assign row_hs  = row_val && row_ready;
  assign last_hs = row_hs && (idx_q == LAST_IDX);

  assign row_idx  = idx_q;
  assign row_last = row_val && (idx_q == LAST_IDX);
  assign row_data = row_val ? buf_q[idx_q] : '0;
  assign ovf      = ovf_q;

  // Next-state, row index, buffer and overflow logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    ovf_d   = ovf_q;
`ifdef TILE_DBUF_EN
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
`endif

    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = DRAIN;
          idx_d   = '0;
          buf_d   = tile_in;
        end
      end
      DRAIN: begin
        if (row_hs) begin
          idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
`ifdef TILE_DBUF_EN
        if (last_hs) begin
          if (pend_vld_q) begin
            // Promote the queued tile; its row 0 shows next cycle.
            buf_d      = pend_q;
            pend_vld_d = 1'b0;
          end else if (capture) begin
            // Tile arriving exactly at the end of a drain goes straight
            // into the active buffer rather than through the pending slot.
            buf_d = tile_in;
          end else begin
            state_d = IDLE;
          end
        end else if (capture) begin
          pend_d     = tile_in;
          pend_vld_d = 1'b1;
        end
`else
        if (last_hs) begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // A fresh overflow wins over a simultaneous clear.
    if (tile_val && !tile_rdy) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Control state: asynchronously cleared so outputs drop without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  // Active tile storage; contents are don't-care until the first capture.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

`ifdef TILE_DBUF_EN
  // Pending-slot valid flag; clearing it on reset discards a queued tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_q <= 1'b0;
    end else begin
      pend_vld_q <= pend_vld_d;
    end
  end

  // Pending tile storage; only meaningful while pend_vld_q is set.
  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end
`endif

endmodule

// File: tb/tb_tile_row_drain.sv
// Directed self-checking bench for tile_row_drain (NUM_PE = 8).
// Tile element [r][c] = base + 8r + c; base distinguishes successive tiles.
// Expectations follow the TILE_DBUF_EN setting of the build.
module tb_tile_row_drain;

  localparam int DW = 16;
  localparam int NP = 8;

  logic                          clk;
  logic                          rst_n;
  logic [NP-1:0][NP-1:0][DW-1:0] tile_in;
  logic                          tile_val;
  logic                          tile_rdy;
  logic [NP-1:0][DW-1:0]         row_data;
  logic                          row_val;
  logic                          row_ready;
  logic [2:0]                    row_idx;
  logic                          row_last;
  logic                          ovf;
  logic                          ovf_clr;

  int n_cmp = 0;
  int n_bad = 0;

  int idx_pat[11] = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7};
  int rdy_pat[11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};

`ifdef TILE_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  tile_row_drain #(.DATA_WIDTH(DW), .NUM_PE(NP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tile_in   (tile_in),
    .tile_val  (tile_val),
    .tile_rdy  (tile_rdy),
    .row_data  (row_data),
    .row_val   (row_val),
    .row_ready (row_ready),
    .row_idx   (row_idx),
    .row_last  (row_last),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_tile(input int base);
    for (int r = 0; r < NP; r++)
      for (int c = 0; c < NP; c++)
        tile_in[r][c] = DW'(base + 8 * r + c);
  endtask

  task automatic expect_row(input string tag, input int r, input int base);
    logic [NP-1:0][DW-1:0] exp_row;
    for (int c = 0; c < NP; c++) exp_row[c] = DW'(base + 8 * r + c);
    chk({tag, "_val"},  128'(row_val), 128'(1));
    chk({tag, "_idx"},  128'(row_idx), 128'(r));
    chk({tag, "_data"}, 128'(row_data), 128'(exp_row));
    chk({tag, "_last"}, 128'(row_last), 128'(r == NP - 1));
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_val"},  128'(row_val), 128'(0));
    chk({tag, "_data"}, 128'(row_data), 128'(0));
    chk({tag, "_last"}, 128'(row_last), 128'(0));
    chk({tag, "_rdy"},  128'(tile_rdy), 128'(1));
  endtask

  initial begin
    rst_n     = 1'b0;
    tile_val  = 1'b0;
    row_ready = 1'b1;
    ovf_clr   = 1'b0;
    tile_in   = '0;

    // Reset state
    #2;
    expect_idle("rst");
    chk("rst_idx", 128'(row_idx), 128'(0));
    chk("rst_ovf", 128'(ovf), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single tile, row_ready high: 8 consecutive rows
    @(negedge clk);
    load_tile(0);
    tile_val = 1'b1;
    chk("t1_pre_val", 128'(row_val), 128'(0));
    for (int r = 0; r < NP; r++) begin
      @(negedge clk);
      tile_val = 1'b0;
      expect_row("t1", r, 0);
      chk("t1_rdy", 128'(tile_rdy), 128'(DBUF));
    end
    @(negedge clk);
    expect_idle("t1_end");

    // Backpressure on row 2 for three cycles
    @(negedge clk);
    load_tile(64);
    tile_val = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      tile_val  = 1'b0;
      expect_row("t2", idx_pat[i], 64);
      row_ready = rdy_pat[i][0];
    end
    @(negedge clk);
    expect_idle("t2_end");

    // Second tile pulsed during row 4
    @(negedge clk);
    load_tile(0);
    tile_val = 1'b1;
    for (int r = 0; r < NP; r++) begin
      @(negedge clk);
      tile_val = 1'b0;
      expect_row("t3", r, 0);
      if (r == 4) begin
        load_tile(128);
        tile_val = 1'b1;
      end
      if (r == 5) chk("t3_ovf", 128'(ovf), 128'(!DBUF));
    end
    if (DBUF) begin
      for (int r = 0; r < NP; r++) begin
        @(negedge clk);
        expect_row("t3b", r, 128);
      end
    end
    @(negedge clk);
    expect_idle("t3_end");
    chk("t3_end_ovf", 128'(ovf), 128'(!DBUF));
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("t3_clr_ovf", 128'(ovf), 128'(0));

    // Tile arriving on the last-row handshake
    @(negedge clk);
    load_tile(0);
    tile_val = 1'b1;
    for (int r = 0; r < NP; r++) begin
      @(negedge clk);
      tile_val = 1'b0;
      expect_row("t4", r, 0);
    end
    load_tile(64);
    tile_val = 1'b1;
    if (DBUF) begin
      for (int r = 0; r < NP; r++) begin
        @(negedge clk);
        tile_val = 1'b0;
        expect_row("t4b", r, 64);
        chk("t4b_ovf", 128'(ovf), 128'(0));
      end
    end
    @(negedge clk);
    tile_val = 1'b0;
    expect_idle("t4_end");
    chk("t4_end_ovf", 128'(ovf), 128'(!DBUF));
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("t4_clr_ovf", 128'(ovf), 128'(0));

    // ovf clear alone, then clear coincident with a dropped tile
    load_tile(0);
    tile_val = 1'b1;
    @(negedge clk);
    expect_row("t5", 0, 0);
    load_tile(64);
    @(negedge clk);
    expect_row("t5", 1, 0);
    load_tile(128);
    @(negedge clk);
    tile_val = 1'b0;
    expect_row("t5", 2, 0);
    chk("t5_ovf_set", 128'(ovf), 128'(1));
    ovf_clr = 1'b1;
    @(negedge clk);
    expect_row("t5", 3, 0);
    chk("t5_ovf_clr", 128'(ovf), 128'(0));
    chk("t5_rdy", 128'(tile_rdy), 128'(0));
    tile_val = 1'b1;
    @(negedge clk);
    tile_val = 1'b0;
    ovf_clr  = 1'b0;
    expect_row("t5", 4, 0);
    chk("t5_ovf_both", 128'(ovf), 128'(1));
    for (int r = 5; r < NP; r++) begin
      @(negedge clk);
      expect_row("t5", r, 0);
    end
    if (DBUF) begin
      for (int r = 0; r < NP; r++) begin
        @(negedge clk);
        expect_row("t5b", r, 64);
      end
    end
    @(negedge clk);
    expect_idle("t5_end");
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("t5_end_ovf", 128'(ovf), 128'(0));

    // Asynchronous reset during row 5, then restart
    load_tile(0);
    tile_val = 1'b1;
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      tile_val = 1'b0;
      expect_row("t6", r, 0);
      if (r == 3) begin
        load_tile(128);
        tile_val = 1'b1;
      end
    end
    chk("t6_pre_ovf", 128'(ovf), 128'(!DBUF));
    #2;
    rst_n = 1'b0;
    #1;
    expect_idle("t6_rst");
    chk("t6_rst_idx", 128'(row_idx), 128'(0));
    chk("t6_rst_ovf", 128'(ovf), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    expect_idle("t6_rel");
    @(negedge clk);
    expect_idle("t6_rel2");
    load_tile(64);
    tile_val = 1'b1;
    for (int r = 0; r < NP; r++) begin
      @(negedge clk);
      tile_val = 1'b0;
      expect_row("t6b", r, 64);
    end
    @(negedge clk);
    expect_idle("t6_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tile_row_drain.md
TILE_ROW_DRAIN -- requirements
Module: tile_row_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of one matrix element chunk.
REQ-002 SHALL have parameter NUM_PE, default 8, tile dimension (NUM_PE x NUM_PE chunks).
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tile_in  input  DATA_WIDTH x [NUM_PE][NUM_PE]  transposed tile from the switch network; [r][c] is row r, column c.
REQ-006 SHALL have port tile_val  input  1  one-cycle pulse: tile_in holds a complete tile this cycle; no backpressure possible upstream.
REQ-007 SHALL have port tile_rdy  output  1  a tile presented this cycle will be captured.
REQ-008 SHALL have port row_data  output  DATA_WIDTH x [NUM_PE]  current row being streamed.
REQ-009 SHALL have port row_val  output  1  row_data valid.
REQ-010 SHALL have port row_ready  input  1  downstream accepts row_data.
REQ-011 SHALL have port row_idx  output  clog2(NUM_PE)  index of current row.
REQ-012 SHALL have port row_last  output  1  row_val and row_idx == NUM_PE-1.
REQ-013 SHALL have port ovf  output  1  sticky: a tile_val pulse arrived with tile_rdy low.
REQ-014 SHALL have port ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-015 SHALL implement FSM states IDLE and DRAIN; IDLE -> DRAIN on capture; DRAIN -> IDLE on last-row handshake with no pending tile.
REQ-016 Capture SHALL occur on a posedge with tile_val && tile_rdy; the whole tile is registered in that edge.
REQ-017 Latency: row_val SHALL assert the cycle after capture with row_idx = 0 and row_data = tile_in[0][*] as captured.
REQ-018 Row handshake = row_val && row_ready; row_idx SHALL increment by 1 per handshake and hold otherwise; row_data and row_val SHALL be stable while row_val && !row_ready.
REQ-019 On handshake at row_idx = NUM_PE-1, row_idx SHALL wrap to 0; if no pending tile, row_val SHALL deassert next cycle.
REQ-020 row_data SHALL read 0 whenever row_val is low.
REQ-021 tile_val with tile_rdy low SHALL drop the tile, leave buffered data and the drain sequence unchanged, and set ovf on the next edge.
REQ-022 ovf_clr SHALL clear ovf next edge; simultaneous ovf_clr and new overflow SHALL leave ovf set.
REQ-023 Throughput with row_ready held high SHALL be one row per cycle, NUM_PE cycles per tile.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, row_val 0, row_idx 0, row_last 0, row_data 0, ovf 0, pending tile discarded, independent of clk.
REQ-025 Reset asserted mid-drain SHALL abandon the tile; after release, tile_rdy SHALL be 1 and the first row_val SHALL follow a fresh capture only.
REQ-026 Tile buffer storage SHALL NOT require reset.

Configuration
REQ-027 Macro TILE_DBUF_EN SHALL select buffering depth.
REQ-028 Without TILE_DBUF_EN: one tile buffer; tile_rdy = (state == IDLE); a tile arriving in the same cycle as the last-row handshake SHALL be dropped with ovf set.
REQ-029 With TILE_DBUF_EN: second pending buffer; tile_rdy = pending buffer empty; a tile captured in DRAIN SHALL become pending, and after the last-row handshake row_idx 0 of the pending tile SHALL be presented the next cycle with no bubble.
REQ-030 With TILE_DBUF_EN, a capture coinciding with the last-row handshake while the pending buffer is empty SHALL be drained next with no bubble; a tile_val while the pending buffer is full SHALL overflow per REQ-021.

Verification (NUM_PE = 8, tile element [r][c] = 8r+c)
REQ-031 Single tile, row_ready = 1 -> rows 0..7 in 8 consecutive cycles starting 1 cycle after tile_val, row_data[c] = 8r+c, row_last only on row 7, then row_val = 0.
REQ-032 Backpressure: row_ready low 3 cycles on row 2 -> row_idx 2 and row_data stable for those cycles, total drain 11 cycles, no data loss.
REQ-033 Second tile pulsed during row 4 of first -> without TILE_DBUF_EN: dropped, ovf = 1, only tile 1 emitted; with TILE_DBUF_EN: 16 back-to-back rows, ovf = 0.
REQ-034 rst_n low during row 5 -> outputs zero asynchronously before next clk; new tile after release restarts at row 0.
REQ-035 ovf set, then ovf_clr pulse with no tile_val -> ovf = 0 next cycle; ovf_clr coincident with dropped tile -> ovf stays 1.
